// File: rtl/hc595_pkg.sv
// Shared types and constants for the 74HC595 seven-segment scan driver.
package hc595_pkg;

   // Scan FSM states
   typedef enum logic [1:0] {
      StLoad,
      StShift,
      StLatch,
      StWait
   } state_e;

   // Frame is {seg[7:0], sel[7:0]}, shifted MSB first into two chained 595s
   localparam int unsigned FRAME_W = 16;

   // Common-anode segment codes, active low, bit7 = dp, bits6..0 = g..a
   localparam logic [7:0] SEG_LUT [16] = '{
      8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
   };

   localparam logic [7:0] SEG_BLANK = 8'hFF;

endpackage

// File: rtl/hc595_scan_driver_if.sv
// Display data in, 74HC595 control lines out.
interface hc595_scan_driver_if;
   logic [31:0] disp_data;
   logic [7:0]  dp;
   logic        SH_CP;
   logic        ST_CP;
   logic        DS;
   logic        frame_done;

   // Source of the display data (register block side)
   modport master (
      output disp_data,
      output dp,
      input  SH_CP,
      input  ST_CP,
      input  DS,
      input  frame_done
   );

   // Scan driver side
   modport slave (
      input  disp_data,
      input  dp,
      output SH_CP,
      output ST_CP,
      output DS,
      output frame_done
   );
endinterface

// File: rtl/hex7seg_decode.sv
// Nibble to common-anode segment code, with decimal point and blanking.
module hex7seg_decode
   import hc595_pkg::*;
(
   input  logic [3:0] nibble_i,
   input  logic       dp_i,
   input  logic       blank_i,
   output logic [7:0] seg_o
);

   // Look up the glyph, light the dp if asked, blanking overrides both
   always_comb begin
      seg_o = SEG_LUT[nibble_i];
      if (dp_i) begin
         seg_o[7] = 1'b0;
      end
      if (blank_i) begin
         seg_o = SEG_BLANK;
      end
   end

endmodule

// File: rtl/hc595_scan_driver.sv
// Time-multiplexed 8-digit hex display through two chained 74HC595s.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits
// (digit 0 is always shown).
module hc595_scan_driver
   import hc595_pkg::*;
#(
   parameter int unsigned CLK_DIV     = 2,
   parameter int unsigned SCAN_CYCLES = 50000,
   parameter int unsigned NUM_DIGITS  = 8
) (
   input  logic                clk,
   input  logic                reset,
   hc595_scan_driver_if.slave  bus_io
);

   localparam int unsigned SlotW = $clog2(SCAN_CYCLES);
   localparam int unsigned DivW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [SlotW-1:0] SlotLast = SlotW'(SCAN_CYCLES - 1);
   localparam logic [DivW-1:0]  DivLast  = DivW'(CLK_DIV - 1);
   localparam logic [2:0]       IdxLast  = 3'(NUM_DIGITS - 1);

   state_e               state_q;
   logic [2:0]           idx_q;
   logic [SlotW-1:0]     slot_q;
   logic [DivW-1:0]      div_q;
   logic [3:0]           bit_q;
   logic [FRAME_W-1:0]   frame_q;
   logic                 sh_q, st_q, ds_q, fd_q;

   logic [3:0]           nibble;
   logic                 dp_sel;
   logic                 blank;
   logic [7:0]           seg;
   logic [7:0]           sel;
   logic [FRAME_W-1:0]   frame_d;

   // Select the current digit's inputs and assemble its frame
   always_comb begin
      nibble  = bus_io.disp_data[{idx_q, 2'b00} +: 4];
      dp_sel  = bus_io.dp[idx_q];
`ifdef LEADING_ZERO_BLANK_EN
      blank   = (idx_q != 3'd0) && ((bus_io.disp_data >> {idx_q, 2'b00}) == 32'd0);
`else
      blank   = 1'b0;
`endif
      sel     = ~(8'b1 << idx_q);
      frame_d = {seg, sel};
   end

   hex7seg_decode u_decode (
      .nibble_i (nibble),
      .dp_i     (dp_sel),
      .blank_i  (blank),
      .seg_o    (seg)
   );

   // Scan FSM: load, shift 16 bits, latch, then idle out the rest of the slot
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StLoad;
         idx_q   <= 3'd0;
         slot_q  <= '0;
         div_q   <= '0;
         bit_q   <= 4'd0;
         frame_q <= '0;
         sh_q    <= 1'b0;
         st_q    <= 1'b0;
         ds_q    <= 1'b0;
         fd_q    <= 1'b0;
      end else begin
         fd_q   <= 1'b0;
         slot_q <= slot_q + SlotW'(1);
         case (state_q)
            StLoad: begin
               // slot_q counts cycles since the LOAD cycle
               slot_q  <= SlotW'(1);
               frame_q <= frame_d;
               ds_q    <= frame_d[FRAME_W-1];
               sh_q    <= 1'b0;
               div_q   <= '0;
               bit_q   <= 4'd15;
               state_q <= StShift;
            end
            StShift: begin
               if (div_q == DivLast) begin
                  div_q <= '0;
                  if (!sh_q) begin
                     sh_q <= 1'b1;
                  end else begin
                     sh_q <= 1'b0;
                     if (bit_q == 4'd0) begin
                        st_q    <= 1'b1;
                        state_q <= StLatch;
                     end else begin
                        // Next bit goes out on the SH_CP falling edge
                        bit_q   <= bit_q - 4'd1;
                        frame_q <= frame_q << 1;
                        ds_q    <= frame_q[FRAME_W-2];
                     end
                  end
               end else begin
                  div_q <= div_q + DivW'(1);
               end
            end
            StLatch: begin
               if (div_q == DivLast) begin
                  div_q   <= '0;
                  st_q    <= 1'b0;
                  fd_q    <= 1'b1;
                  state_q <= StWait;
               end else begin
                  div_q <= div_q + DivW'(1);
               end
            end
            StWait: begin
               if (slot_q == SlotLast) begin
                  idx_q   <= (idx_q == IdxLast) ? 3'd0 : idx_q + 3'd1;
                  state_q <= StLoad;
               end
            end
            default: state_q <= StLoad;
         endcase
      end
   end

   assign bus_io.SH_CP      = sh_q;
   assign bus_io.ST_CP      = st_q;
   assign bus_io.DS         = ds_q;
   assign bus_io.frame_done = fd_q;

endmodule

// File: tb/tb_hc595_scan_driver.sv
// Bench for hc595_scan_driver: per-cycle waveform model plus literal frame checks.
module tb_hc595_scan_driver;

   localparam int unsigned D    = 2;
   localparam int unsigned SCAN = 80;

   logic clk;
   logic reset;
   hc595_scan_driver_if bus ();

   hc595_scan_driver #(
      .CLK_DIV     (D),
      .SCAN_CYCLES (SCAN),
      .NUM_DIGITS  (8)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .bus_io (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks;
   int errors;

   // Model state: position within the current slot and digit being shown
   bit          m_valid;
   bit          m_rst;
   int          m_c;
   int          m_digit;
   logic [15:0] m_frame;
   int          nrise;
   logic        sh_prev;
   logic [15:0] shreg;
   logic [15:0] captured [8];

   function automatic logic [7:0] seg_of(logic [3:0] n);
      case (n)
         4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
         4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
         4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
         4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
      endcase
   endfunction

   function automatic logic [15:0] exp_frame(logic [31:0] data, logic [7:0] dpv, int d);
      logic [7:0]  s;
      logic [7:0]  sl;
      logic [31:0] hi;
      hi = data >> (4 * d);
      s  = seg_of(hi[3:0]);
      if (dpv[d]) s[7] = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      if (d >= 1 && hi == 32'd0) s = 8'hFF;
`endif
      sl = ~(8'd1 << d);
      return {s, sl};
   endfunction

   task automatic check1(string name, logic act, logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0t digit=%0d c=%0d got %b want %b", name, $time, m_digit, m_c,
                  act, exp);
      end
   endtask

   task automatic check16(string name, logic [15:0] act, logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0t got %h want %h", name, $time, act, exp);
      end
   endtask

   // Compare process: check every cycle against the model, then advance the model
   initial begin
      logic e_sh, e_st, e_fd, e_ds;
      bit   in_shift;
      m_valid = 0; m_rst = 0; m_c = 0; m_digit = 0; m_frame = '0;
      nrise = 0; sh_prev = 1'b0; shreg = '0;
      forever begin
         @(negedge clk);
         if (m_valid) begin
            in_shift = (m_c >= 1) && (m_c <= 32 * D);
            e_sh = 1'b0;
            e_ds = 1'b0;
            if (in_shift) begin
               e_sh = ((m_c - 1) % (2 * D)) >= D;
               e_ds = m_frame[15 - (m_c - 1) / (2 * D)];
            end
            e_st = (m_c >= 32 * D + 1) && (m_c <= 33 * D);
            e_fd = (m_c == 33 * D + 1);
            check1("SH_CP", bus.SH_CP, e_sh);
            check1("ST_CP", bus.ST_CP, e_st);
            check1("frame_done", bus.frame_done, e_fd);
            if (in_shift || m_rst) check1("DS", bus.DS, e_ds);
            // Independent observer: reassemble the serial frame from SH_CP rises
            if (bus.SH_CP === 1'b1 && sh_prev === 1'b0) begin
               shreg = {shreg[14:0], bus.DS};
               nrise++;
            end
            if (bus.frame_done === 1'b1) begin
               checks++;
               if (nrise != 16) begin
                  errors++;
                  $display("FAIL sh_rises t=%0t got %0d want 16", $time, nrise);
               end
               check16("frame_vs_model", shreg, m_frame);
               captured[m_digit] = shreg;
               nrise = 0;
            end
         end
         sh_prev = bus.SH_CP;
         if (reset) begin
            m_valid = 1; m_c = 0; m_digit = 0; m_rst = 1; nrise = 0;
         end else if (m_valid) begin
            if (m_c == 0) begin
               m_frame = exp_frame(bus.disp_data, bus.dp, m_digit);
               m_c = 1;
               m_rst = 0;
            end else if (m_c == SCAN - 1) begin
               m_c = 0;
               m_digit = (m_digit + 1) % 8;
            end else begin
               m_c++;
            end
         end
      end
   end

   task automatic run(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Bounded wait for the cycle with the given digit/slot position
   task automatic wait_for(int d, int c);
      bit found;
      found = 0;
      for (int i = 0; i < 2000 && !found; i++) begin
         @(posedge clk);
         if (m_digit == d && m_c == c) found = 1;
      end
      #1;
      if (!found) begin
         checks++;
         errors++;
         $display("FAIL wait_for digit=%0d c=%0d timed out", d, c);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      for (int i = 0; i < 8; i++) captured[i] = '0;
      reset = 1'b1;
      bus.disp_data = 32'h01234567;
      bus.dp = 8'h00;
      run(5);
      reset = 1'b0;

      // Basic scan of all eight digits
      run(8 * SCAN + 5);
      check16("d0_01234567", captured[0], 16'hF8FE);
      check16("d1_01234567", captured[1], 16'h82FD);
`ifdef LEADING_ZERO_BLANK_EN
      check16("d7_01234567", captured[7], 16'hFF7F);
`else
      check16("d7_01234567", captured[7], 16'hC07F);
`endif

      // Decimal point
      bus.disp_data = 32'h00000010;
      bus.dp = 8'h02;
      run(8 * SCAN + 5);
      check16("d1_dp", captured[1], 16'h79FD);

      // Input change mid-shift must not disturb the frame in flight
      bus.disp_data = 32'h0;
      bus.dp = 8'h00;
      wait_for(3, 10);
      bus.disp_data = 32'hFFFFFFFF;
      wait_for(5, 0);
`ifdef LEADING_ZERO_BLANK_EN
      check16("d3_midchange", captured[3], 16'hFFF7);
`else
      check16("d3_midchange", captured[3], 16'hC0F7);
`endif
      check16("d4_after", captured[4], 16'h8EEF);

      // Reset at bit 9 of digit 5 aborts the frame; scan restarts at digit 0
      wait_for(5, 1 + 6 * 2 * D + 1);
      reset = 1'b1;
      run(1);
      reset = 1'b0;
      captured[0] = '0;
      run(33 * D + 5);
      check16("d0_after_reset", captured[0], 16'h8EFE);

      // Random data across 20+ slots, including the 7->0 wrap
      for (int i = 0; i < 43; i++) begin
         bus.disp_data = $urandom;
         bus.dp = 8'($urandom_range(0, 255));
         run(37);
      end

      // Leading-zero handling
      bus.disp_data = 32'h00000042;
      bus.dp = 8'h00;
      run(9 * SCAN);
      check16("d0_42", captured[0], 16'hA4FE);
      check16("d1_42", captured[1], 16'h99FD);
`ifdef LEADING_ZERO_BLANK_EN
      check16("d2_42", captured[2], 16'hFFFB);
      check16("d7_42", captured[7], 16'hFF7F);
`else
      check16("d2_42", captured[2], 16'hC0FB);
      check16("d7_42", captured[7], 16'hC07F);
`endif
      bus.disp_data = 32'h0;
      run(9 * SCAN);
      check16("d0_zero", captured[0], 16'hC0FE);
`ifdef LEADING_ZERO_BLANK_EN
      check16("d3_zero", captured[3], 16'hFFF7);
`else
      check16("d3_zero", captured[3], 16'hC0F7);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
